// File: rtl/shift_agc_ctrl_if.sv
// shift_agc_ctrl_if: wide signed I/Q sample bus with its valid qualifier
// Ports (modports):
//   master - drives data_in_I, data_in_Q, data_valid (sample source)
//   slave  - receives data_in_I, data_in_Q, data_valid (shift_agc_ctrl)
interface shift_agc_ctrl_if #(
  parameter int in_width = 88
);
  logic signed [in_width-1:0] data_in_I;
  logic signed [in_width-1:0] data_in_Q;
  logic                       data_valid;
  modport master (output data_in_I, data_in_Q, data_valid);
  modport slave  (input  data_in_I, data_in_Q, data_valid);
endinterface

// File: rtl/shift_agc_ctrl.sv
// shift_agc_ctrl: windowed headroom measurement driving the I/Q output shift distance
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_in                slave sample bus (data_in_I, data_in_Q, data_valid)
//   manual_en           1 = bypass AGC and follow manual_distance
//   manual_distance     manual shift value, clamped to MAX_SHIFT
//   distance            shift distance to the shifter
//   dist_upd            one-cycle pulse, coincident with a new distance value
//   clip                one-cycle pulse when a sample has less headroom than distance
//   peak_headroom       minimum headroom of the last completed window
// Optional feature: define SHIFT_AGC_FAST_ATTACK_EN to lower distance immediately
// on a clipping sample instead of waiting for the window end.
module shift_agc_ctrl #(
  parameter int in_width      = 88,
  parameter int WINDOW_LEN    = 1024,
  parameter int HEADROOM_BITS = 1,
  parameter int DECAY_HOLD    = 4,
  parameter int DECAY_STEP    = 1,
  parameter int MAX_SHIFT     = 56,
  parameter int INIT_DISTANCE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_agc_ctrl_if.slave       s_in,
  input  logic                  manual_en,
  input  logic [7:0]            manual_distance,
  output logic [7:0]            distance,
  output logic                  dist_upd,
  output logic                  clip,
  output logic [7:0]            peak_headroom
);
  localparam int CW = $clog2(WINDOW_LEN + 1);
  localparam logic [7:0]    H_MAX = 8'(in_width - 1);
  localparam logic [7:0]    M_MAX = 8'(MAX_SHIFT);
  localparam logic [7:0]    HB    = 8'(HEADROOM_BITS);
  localparam logic [7:0]    DS    = 8'(DECAY_STEP);
  localparam logic [7:0]    DH    = 8'(DECAY_HOLD);
  localparam logic [CW-1:0] WL    = CW'(WINDOW_LEN);
  typedef enum logic [1:0] {MEASURE, UPDATE, MANUAL} state_t;
  state_t                r_state;
  logic [in_width-1:0]   r_i, r_q;
  logic                  r_v1, r_v2, r_upd, r_clip;
  logic [7:0]            r_hs, r_min, r_hold, r_dist, r_peak;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            w_hi, w_hq, w_hs, w_min, w_sub, w_safe, w_gap, w_rise, w_hold_inc, w_man, w_dist;
  logic                  w_hit;
  // Counts bits below the sign bit that still equal it; stops at the first differing bit.
  function automatic logic [7:0] headroom(input logic [in_width-1:0] x);
    logic [7:0] h;
    logic       run;
    h   = '0;
    run = 1'b1;
    for (int k = in_width - 2; k >= 0; k--) begin
      run = run & (x[k] == x[in_width-1]);
      h   = h + 8'(run);
    end
    return h;
  endfunction
  assign w_hi       = headroom(r_i);
  assign w_hq       = headroom(r_q);
  assign w_hs       = (w_hi < w_hq) ? w_hi : w_hq;
  assign w_min      = (r_hs < r_min) ? r_hs : r_min;
  assign w_sub      = (r_min > HB) ? r_min - HB : 8'd0;
  assign w_safe     = (w_sub > M_MAX) ? M_MAX : w_sub;
  assign w_gap      = w_safe - r_dist;
  assign w_rise     = r_dist + ((DS < w_gap) ? DS : w_gap);
  assign w_hold_inc = r_hold + 8'd1;
  assign w_man      = (manual_distance > M_MAX) ? M_MAX : manual_distance;
  assign w_hit      = r_v2 && (r_hs < r_dist);
  always_comb begin
    w_dist = r_dist;
    if (manual_en)
      w_dist = w_man;
    else if (r_state == UPDATE)
      w_dist = (w_safe < r_dist) ? w_safe :
               (w_safe > r_dist && w_hold_inc >= DH) ? w_rise : r_dist;
`ifdef SHIFT_AGC_FAST_ATTACK_EN
    else if (r_state == MEASURE && w_hit)
      w_dist = (r_hs > HB) ? r_hs - HB : 8'd0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i     <= '0;
      r_q     <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_hs    <= '0;
      r_state <= MEASURE;
      r_cnt   <= '0;
      r_min   <= H_MAX;
      r_hold  <= '0;
      r_dist  <= 8'(INIT_DISTANCE);
      r_upd   <= 1'b0;
      r_clip  <= 1'b0;
      r_peak  <= H_MAX;
    end else begin
      r_i    <= s_in.data_in_I;
      r_q    <= s_in.data_in_Q;
      r_v1   <= s_in.data_valid;
      r_hs   <= w_hs;
      r_v2   <= r_v1;
      r_clip <= w_hit;
      r_dist <= w_dist;
      r_upd  <= (w_dist != r_dist);
      if (manual_en) begin
        r_state <= MANUAL;
        r_cnt   <= '0;
        r_min   <= H_MAX;
        r_hold  <= '0;
      end else if (r_state == MANUAL) begin
        r_state <= MEASURE;
      end else if (r_state == UPDATE) begin
        // A sample landing here opens the next window rather than being lost.
        r_state <= MEASURE;
        r_peak  <= r_min;
        r_cnt   <= r_v2 ? CW'(1) : '0;
        r_min   <= r_v2 ? r_hs : H_MAX;
        r_hold  <= (w_safe > r_dist && w_hold_inc < DH) ? w_hold_inc : '0;
      end else if (r_v2) begin
        r_cnt <= r_cnt + CW'(1);
        r_min <= w_min;
        if (r_cnt + CW'(1) == WL)
          r_state <= UPDATE;
`ifdef SHIFT_AGC_FAST_ATTACK_EN
        if (w_hit)
          r_hold <= '0;
`endif
      end
    end
  end
  assign distance      = r_dist;
  assign dist_upd      = r_upd;
  assign clip          = r_clip;
  assign peak_headroom = r_peak;
endmodule

// File: tb/tb_shift_agc_ctrl.sv
// tb_shift_agc_ctrl: directed-vector bench for shift_agc_ctrl (WINDOW_LEN=16, DECAY_HOLD=2, DECAY_STEP=8)
module tb_shift_agc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        manual_en = 1'b0;
  logic [7:0]  manual_distance = 8'd0;
  logic [7:0]  distance, peak_headroom;
  logic        dist_upd, clip;
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic [87:0] c40, n70, c76;
  shift_agc_ctrl_if #(.in_width(88)) bus ();
  shift_agc_ctrl #(
    .in_width(88), .WINDOW_LEN(16), .HEADROOM_BITS(1), .DECAY_HOLD(2),
    .DECAY_STEP(8), .MAX_SHIFT(56), .INIT_DISTANCE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_in(bus), .manual_en(manual_en),
    .manual_distance(manual_distance), .distance(distance), .dist_upd(dist_upd),
    .clip(clip), .peak_headroom(peak_headroom)
  );
  always #5 clk = ~clk;
  task automatic step(input logic v, input logic [87:0] i, input logic [87:0] q);
    bus.data_valid = v;
    bus.data_in_I  = i;
    bus.data_in_Q  = q;
    @(negedge clk);
    n++;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    manual_en = 1'b0;
    manual_distance = 8'd0;
    bus.data_valid = 1'b0;
    bus.data_in_I = '0;
    bus.data_in_Q = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask
  task automatic test_reset;
    do_reset();
    checks++;
    if (distance !== 8'd0 || dist_upd !== 1'b0 || clip !== 1'b0 || peak_headroom !== 8'd87) begin
      errors++;
      $display("FAIL reset_init got dist=%0d upd=%0b clip=%0b peak=%0d expected 0/0/0/87", distance, dist_upd, clip, peak_headroom);
    end
    manual_en = 1'b1;
    manual_distance = 8'd30;
    step(1'b0, '0, '0);
    checks++;
    if (distance !== 8'd30 || dist_upd !== 1'b1) begin
      errors++;
      $display("FAIL reset_premanual got dist=%0d upd=%0b expected 30/1", distance, dist_upd);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (distance !== 8'd0 || dist_upd !== 1'b0 || clip !== 1'b0 || peak_headroom !== 8'd87) begin
      errors++;
      $display("FAIL reset_async got dist=%0d upd=%0b clip=%0b peak=%0d expected 0/0/0/87", distance, dist_upd, clip, peak_headroom);
    end
    manual_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 19; k++) begin
      step(1'b1, c40, '0);
      if (n == 18 || n == 19) begin
        checks++;
        if (peak_headroom !== ((n == 19) ? 8'd46 : 8'd87)) begin
          errors++;
          $display("FAIL reset_measure n=%0d got peak=%0d expected %0d", n, peak_headroom, (n == 19) ? 46 : 87);
        end
      end
    end
  endtask
  task automatic test_headroom;
    int upd = 0;
    int w, e;
    do_reset();
    for (int k = 1; k <= 224; k++) begin
      step(1'b1, c40, '0);
      if (dist_upd === 1'b1) upd++;
      if (n > 3 && (n - 3) % 16 == 0) begin
        w = (n - 3) / 16;
        e = (w / 2) * 8;
        if (e > 45) e = 45;
        checks++;
        if (distance !== 8'(e)) begin
          errors++;
          $display("FAIL headroom_dist window=%0d got %0d expected %0d", w, distance, e);
        end
        if (w == 1) begin
          checks++;
          if (peak_headroom !== 8'd46) begin
            errors++;
            $display("FAIL headroom_peak got %0d expected 46", peak_headroom);
          end
        end
      end
    end
    checks++;
    if (upd != 6) begin
      errors++;
      $display("FAIL headroom_upd_count got %0d expected 6", upd);
    end
  endtask
  task automatic test_attack;
    int e;
    for (int k = 225; k <= 275; k++) begin
      step(1'b1, (k == 229) ? n70 : c40, '0);
      if (n >= 230 && n <= 232) begin
        checks++;
        if (clip !== (n == 231)) begin
          errors++;
          $display("FAIL attack_clip n=%0d got %0b expected %0b", n, clip, n == 231);
        end
      end
      if (n == 242 || n == 243 || n == 259 || n == 275) begin
`ifdef SHIFT_AGC_FAST_ATTACK_EN
        e = (n == 275) ? 24 : 16;
`else
        e = (n == 242) ? 45 : (n == 275) ? 24 : 16;
`endif
        checks++;
        if (distance !== 8'(e)) begin
          errors++;
          $display("FAIL attack_dist n=%0d got %0d expected %0d", n, distance, e);
        end
      end
      if (n == 243) begin
        checks++;
        if (peak_headroom !== 8'd17) begin
          errors++;
          $display("FAIL attack_peak got %0d expected 17", peak_headroom);
        end
      end
    end
  endtask
  task automatic test_manual;
    int upd = 0;
    do_reset();
    for (int k = 1; k <= 10; k++) step(1'b1, n70, '0);
    manual_en = 1'b1;
    manual_distance = 8'd200;
    step(1'b0, '0, '0);
    checks++;
    if (distance !== 8'd56 || dist_upd !== 1'b1) begin
      errors++;
      $display("FAIL manual_clamp got dist=%0d upd=%0b expected 56/1", distance, dist_upd);
    end
    for (int k = 12; k <= 15; k++) begin
      step(1'b0, '0, '0);
      if (dist_upd === 1'b1) upd++;
    end
    checks++;
    if (upd != 0 || distance !== 8'd56) begin
      errors++;
      $display("FAIL manual_hold got upd=%0d dist=%0d expected 0/56", upd, distance);
    end
    manual_en = 1'b0;
    for (int k = 16; k <= 34; k++) begin
      step(k <= 31, c40, '0);
      if (n == 33) begin
        checks++;
        if (distance !== 8'd56 || peak_headroom !== 8'd87) begin
          errors++;
          $display("FAIL manual_fresh_pre got dist=%0d peak=%0d expected 56/87", distance, peak_headroom);
        end
      end
      if (n == 34) begin
        checks++;
        if (distance !== 8'd45 || peak_headroom !== 8'd46 || dist_upd !== 1'b1) begin
          errors++;
          $display("FAIL manual_fresh_upd got dist=%0d peak=%0d upd=%0b expected 45/46/1", distance, peak_headroom, dist_upd);
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] e;
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      step(k <= 32, (k == 17) ? n70 : c40, '0);
      if (n == 18 || n == 19 || n == 34 || n == 35) begin
        e = (n == 18) ? 8'd87 : (n == 35) ? 8'd17 : 8'd46;
        checks++;
        if (peak_headroom !== e) begin
          errors++;
          $display("FAIL b2b_peak n=%0d got %0d expected %0d", n, peak_headroom, e);
        end
      end
      if (n == 35) begin
        checks++;
        if (distance !== 8'd8 || dist_upd !== 1'b1) begin
          errors++;
          $display("FAIL b2b_dist got dist=%0d upd=%0b expected 8/1", distance, dist_upd);
        end
      end
    end
  endtask
  task automatic test_fast_attack;
    logic [7:0] e;
    do_reset();
    manual_en = 1'b1;
    manual_distance = 8'd45;
    step(1'b0, '0, '0);
    manual_en = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      step(k <= 17, (k == 2) ? c76 : c40, '0);
`ifdef SHIFT_AGC_FAST_ATTACK_EN
      e = (n == 3) ? 8'd45 : 8'd9;
`else
      e = (n == 20) ? 8'd9 : 8'd45;
`endif
      if (n == 3 || n == 4 || n == 19 || n == 20) begin
        checks++;
        if (distance !== e) begin
          errors++;
          $display("FAIL fast_dist n=%0d got %0d expected %0d", n, distance, e);
        end
      end
      if (n == 4) begin
        checks++;
        if (clip !== 1'b1) begin
          errors++;
          $display("FAIL fast_clip got %0b expected 1", clip);
        end
      end
      if (n == 20) begin
        checks++;
        if (peak_headroom !== 8'd10) begin
          errors++;
          $display("FAIL fast_peak got %0d expected 10", peak_headroom);
        end
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    c40 = 88'd1 << 40;
    n70 = -(88'd1 << 70);
    c76 = 88'd1 << 76;
    bus.data_valid = 1'b0;
    bus.data_in_I = '0;
    bus.data_in_Q = '0;
    test_reset();
    test_headroom();
    test_attack();
    test_manual();
    test_back_to_back();
    test_fast_attack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
